store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
  CORE, 0, core id printed in report output
  DATA_WIDTH, 32, data word width
  ADDRESS_BITS, 8, word address width
  DEPTH, 4, buffer entries (power of two, >=2)
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
  clock  input  1  single clock, all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  load  input  1  core load request
  store  input  1  core store request
  address  input  ADDRESS_BITS  core load/store address
  store_data  input  DATA_WIDTH  core store data
  load_data  output  DATA_WIDTH  load result, same cycle
  load_valid  output  1  load_data valid this cycle
  stall  output  1  core must hold its request
  mem_load  output  1  read enable to memory_unit
  mem_store  output  1  write enable to memory_unit
  mem_address  output  ADDRESS_BITS  memory_unit address
  mem_store_data  output  DATA_WIDTH  memory_unit store data
  mem_load_data  input  DATA_WIDTH  memory_unit load data (combinational)
  report  input  1  enables per-cycle $display trace

Function
REQ-003 Storage SHALL be a circular FIFO of DEPTH {address, data} entries; head/tail wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-004 stall SHALL be 1 when count == DEPTH (plus REQ-016 case), else 0.
REQ-005 Enqueue: at a rising edge with store=1, stall=0 and reset=0, the entry {address, store_data} SHALL be written at tail and tail advanced.
REQ-006 A store presented while stall=1 SHALL be ignored; the core holds it until stall=0.
REQ-007 Drain: when count != 0 and load=0, the block SHALL drive mem_store=1 with the head entry on mem_address/mem_store_data and advance head at the next edge.
REQ-008 A load SHALL take priority over drain: load=1 forces mem_store=0 that cycle.
REQ-009 A load SHALL search all valid entries by full-width address compare; on multiple hits the youngest entry wins.
REQ-010 Load miss: mem_load=1, mem_address=address, load_data=mem_load_data, load_valid=1, all in the same cycle (zero latency).
REQ-011 Load hit (forwarding compiled in): load_data=entry data, load_valid=1, mem_load=0.
REQ-012 load=0: load_data=0, load_valid=0, mem_load=0; when idle, mem_address=0 and mem_store_data=0.
REQ-013 Simultaneous load+store: the load searches only pre-existing entries; the store enqueues per REQ-005 and becomes visible to loads from the next cycle.
REQ-014 Simultaneous enqueue and drain SHALL leave count unchanged; at count==DEPTH no enqueue occurs even if draining.
REQ-015 When report=1, each rising edge SHALL $display CORE, the 32-bit cycle counter, count, head, tail and all mem_* signals.

Reset
REQ-016 Reset SHALL set count, head, tail and the cycle counter to 0 and discard all entries without draining them; it overrides a coincident store.
REQ-017 After reset: stall=0, mem_store=0, mem_load=0, load_valid=0, load_data=0.

Configuration
REQ-018 Macro STORE_BUFFER_FWD_EN defined: load hits are forwarded per REQ-011.
REQ-019 Macro undefined: a load hitting any entry SHALL drive stall=1, load_valid=0 and mem_load=0, and drain SHALL proceed despite load=1 until no entry matches; misses follow REQ-010.

Verification
REQ-020 After reset, store (4,9) then (8,5) with no loads -> mem_store pulses addr 4/data 9, then addr 8/data 5, one cycle after each enqueue; count returns to 0.
REQ-021 Hold load at 0x20 (miss), store 0x10..0x13 -> stall=1 after the 4th; a 5th store is ignored; release load -> four in-order drains, then stall=0.
REQ-022 Hold load at 0x30, store (8,5) then (8,7), then load 8 -> with FWD_EN load_data=7 and mem_load=0; without it stall=1 until both drain, then load_data=7 from memory.
REQ-023 Empty buffer, memory[12]=0xAB, load 12 -> mem_load=1, load_data=0xAB, load_valid=1 in the same cycle.
REQ-024 Empty buffer, memory[4]=9, load 4 + store (4,3) together -> load_data=9, entry enqueued; next cycle load 4 -> 3.
REQ-025 Three entries buffered, assert reset one cycle -> count=0, stall=0, no mem_store afterward; memory is unchanged.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO with same-cycle load search and drain.
// Define STORE_BUFFER_FWD_EN to forward load hits; otherwise hits stall.
module store_buffer #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 8,
   parameter int DEPTH        = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    store,
   input  logic [ADDRESS_BITS-1:0] address,
   input  logic [DATA_WIDTH-1:0]   store_data,
   output logic [DATA_WIDTH-1:0]   load_data,
   output logic                    load_valid,
   output logic                    stall,
   output logic                    mem_load,
   output logic                    mem_store,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_store_data,
   input  logic [DATA_WIDTH-1:0]   mem_load_data,
   input  logic                    report
);

   localparam int PW = $clog2(DEPTH);

   logic [ADDRESS_BITS-1:0] entry_address [DEPTH];
   logic [DATA_WIDTH-1:0]   entry_data [DEPTH];
   logic [PW-1:0]           head;
   logic [PW-1:0]           tail;
   logic [PW:0]             count;
   logic [31:0]             cycle;
   logic                    hit;
   logic                    full;
   logic                    enqueue;
   logic                    drain;

`ifdef STORE_BUFFER_FWD_EN
   logic [DATA_WIDTH-1:0]   hit_data;
`endif

   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      hit = 1'b0;
`ifdef STORE_BUFFER_FWD_EN
      hit_data = '0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (((PW+1)'(k) < count) &&
             (entry_address[head + PW'(k)] == address)) begin
            hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
            hit_data = entry_data[head + PW'(k)];
`endif
         end
      end
   end

   assign full = (count == (PW+1)'(DEPTH));

`ifdef STORE_BUFFER_FWD_EN
   assign stall      = reset | full;
   assign drain      = ~reset & (count != '0) & ~load;
   assign load_valid = load;
   assign load_data  = !load ? '0 :
                       hit   ? hit_data : mem_load_data;
`else
   // A hit must wait until the matching stores reach memory.
   assign stall      = reset | full | (load & hit);
   assign drain      = ~reset & (count != '0) & (~load | hit);
   assign load_valid = load & ~hit;
   assign load_data  = load_valid ? mem_load_data : '0;
`endif

   assign mem_load       = load & ~hit;
   assign mem_store      = drain;
   assign mem_address    = mem_load ? address :
                           drain    ? entry_address[head] : '0;
   assign mem_store_data = drain ? entry_data[head] : '0;
   assign enqueue        = store & ~stall;

   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         cycle <= '0;
      end else begin
         cycle <= cycle + 32'd1;
         if (enqueue) tail <= tail + PW'(1);
         if (drain) head <= head + PW'(1);
         count <= count + (PW+1)'(enqueue) - (PW+1)'(drain);
      end
   end

   always_ff @(posedge clock) begin
      if (enqueue) begin
         entry_address[tail] <= address;
         entry_data[tail]    <= store_data;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (report)
         $display("[sb%0d] cycle=%0d count=%0d head=%0d tail=%0d ld=%b st=%b addr=%h data=%h",
                  CORE, cycle, count, head, tail,
                  mem_load, mem_store, mem_address, mem_store_data);
   end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboarded drain checks plus per-scenario load checks.
// Builds for either setting of STORE_BUFFER_FWD_EN.
module tb_store_buffer;

   localparam int DW = 32;
   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } entry_t;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          load = 1'b0;
   logic          store = 1'b0;
   logic          report = 1'b0;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] store_data = '0;
   logic [DW-1:0] load_data;
   logic          load_valid;
   logic          stall;
   logic          mem_load;
   logic          mem_store;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_store_data;
   logic [DW-1:0] mem_load_data;

   logic [DW-1:0] mem [256];
   entry_t        exp_q [$];
   entry_t        got;
   int            tests = 0;
   int            fails = 0;

   store_buffer #(
      .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .DEPTH(4)
   ) dut (
      .clock(clock), .reset(reset), .load(load), .store(store),
      .address(address), .store_data(store_data),
      .load_data(load_data), .load_valid(load_valid), .stall(stall),
      .mem_load(mem_load), .mem_store(mem_store),
      .mem_address(mem_address), .mem_store_data(mem_store_data),
      .mem_load_data(mem_load_data), .report(report)
   );

   always #5 clock = ~clock;

   assign mem_load_data = mem[mem_address];

   always @(posedge clock) begin
      if (mem_store) mem[mem_address] = mem_store_data;
   end

   // Scoreboard: every memory write must be the next expected entry.
   always @(negedge clock) begin
      #2;
      if (mem_store) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL drain_unexpected: got addr %h data %h, required no write",
                     mem_address, mem_store_data);
         end else begin
            got = exp_q.pop_front();
            if (mem_address !== got.a || mem_store_data !== got.d) begin
               fails++;
               $display("FAIL drain_order: got %h/%h required %h/%h",
                        mem_address, mem_store_data, got.a, got.d);
            end
         end
      end
   end

   task automatic drive(input logic l, input logic s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock);
      load = l;
      store = s;
      address = a;
      store_data = d;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b required 0", stall); end
      tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL reset_mem_store: got %b required 0", mem_store); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL reset_mem_load: got %b required 0", mem_load); end
      tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL reset_load_valid: got %b required 0", load_valid); end
      tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL reset_load_data: got %h required 0", load_data); end
      tests++; if (mem_address !== 8'h0) begin fails++; $display("FAIL reset_mem_address: got %h required 0", mem_address); end
   endtask

   task automatic test_drain();
      drive(1'b0, 1'b1, 8'h04, 32'd9);
      exp_q.push_back({8'h04, 32'd9});
      tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL drain_empty: got %b required 0", mem_store); end
      drive(1'b0, 1'b1, 8'h08, 32'd5);
      exp_q.push_back({8'h08, 32'd5});
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL drain_stall: got %b required 0", stall); end
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL drain_idle: got %b required 0", mem_store); end
      tests++; if (mem_store_data !== 32'h0) begin fails++; $display("FAIL drain_idle_data: got %h required 0", mem_store_data); end
      tests++; if (mem[8] !== 32'd5) begin fails++; $display("FAIL drain_mem8: got %h required 5", mem[8]); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, AW'(8'h10 + i), DW'(32'h100 + i));
         exp_q.push_back({AW'(8'h10 + i), DW'(32'h100 + i)});
         tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_fill_stall%0d: got %b required 0", i, stall); end
         tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL full_hold_drain%0d: got %b required 0", i, mem_store); end
         if (i == 0) begin
            tests++; if (load_data !== 32'h77) begin fails++; $display("FAIL full_miss_data: got %h required 77", load_data); end
            tests++; if (mem_load !== 1'b1) begin fails++; $display("FAIL full_miss_mem_load: got %b required 1", mem_load); end
         end
      end
      drive(1'b1, 1'b1, 8'h14, 32'h104);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %b required 1", stall); end
      drive(1'b1, 1'b1, 8'h14, 32'h104);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall_hold: got %b required 1", stall); end
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_release_stall: got %b required 1", stall); end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL full_empty_stall: got %b required 0", stall); end
      tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL full_empty_store: got %b required 0", mem_store); end
      tests++; if (mem[8'h13] !== 32'h103) begin fails++; $display("FAIL full_mem13: got %h required 103", mem[8'h13]); end
   endtask

   task automatic test_forward();
      drive(1'b1, 1'b1, 8'h08, 32'd5);
      exp_q.push_back({8'h08, 32'd5});
      tests++; if (load_data !== 32'd5) begin fails++; $display("FAIL fwd_first_data: got %h required 5", load_data); end
      tests++; if (mem_load !== 1'b1) begin fails++; $display("FAIL fwd_first_mem_load: got %b required 1", mem_load); end
`ifdef STORE_BUFFER_FWD_EN
      drive(1'b1, 1'b1, 8'h08, 32'd7);
      exp_q.push_back({8'h08, 32'd7});
      tests++; if (load_data !== 32'd5) begin fails++; $display("FAIL fwd_hit_data: got %h required 5", load_data); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL fwd_hit_mem_load: got %b required 0", mem_load); end
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL fwd_hit_stall: got %b required 0", stall); end
      drive(1'b1, 1'b0, 8'h08, 32'h0);
      tests++; if (load_data !== 32'd7) begin fails++; $display("FAIL fwd_youngest: got %h required 7", load_data); end
      tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL fwd_valid: got %b required 1", load_valid); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL fwd_youngest_mem_load: got %b required 0", mem_load); end
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
`else
      drive(1'b1, 1'b1, 8'h08, 32'd7);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL nofwd_hit_stall: got %b required 1", stall); end
      tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL nofwd_hit_valid: got %b required 0", load_valid); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL nofwd_hit_mem_load: got %b required 0", mem_load); end
      tests++; if (mem_store !== 1'b1) begin fails++; $display("FAIL nofwd_hit_drain: got %b required 1", mem_store); end
      drive(1'b1, 1'b1, 8'h08, 32'd7);
      exp_q.push_back({8'h08, 32'd7});
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nofwd_retry_stall: got %b required 0", stall); end
      tests++; if (load_data !== 32'd5) begin fails++; $display("FAIL nofwd_retry_data: got %h required 5", load_data); end
      drive(1'b1, 1'b0, 8'h08, 32'h0);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL nofwd_second_stall: got %b required 1", stall); end
      tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL nofwd_second_data: got %h required 0", load_data); end
      drive(1'b1, 1'b0, 8'h08, 32'h0);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL nofwd_final_stall: got %b required 0", stall); end
      tests++; if (load_data !== 32'd7) begin fails++; $display("FAIL nofwd_final_data: got %h required 7", load_data); end
      tests++; if (mem_load !== 1'b1) begin fails++; $display("FAIL nofwd_final_mem_load: got %b required 1", mem_load); end
`endif
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tests++; if (mem[8] !== 32'd7) begin fails++; $display("FAIL fwd_mem8: got %h required 7", mem[8]); end
   endtask

   task automatic test_miss();
      drive(1'b1, 1'b0, 8'd12, 32'h0);
      tests++; if (mem_load !== 1'b1) begin fails++; $display("FAIL miss_mem_load: got %b required 1", mem_load); end
      tests++; if (load_data !== 32'hAB) begin fails++; $display("FAIL miss_data: got %h required ab", load_data); end
      tests++; if (load_valid !== 1'b1) begin fails++; $display("FAIL miss_valid: got %b required 1", load_valid); end
      tests++; if (mem_address !== 8'd12) begin fails++; $display("FAIL miss_address: got %h required 0c", mem_address); end
      drive(1'b0, 1'b0, 8'd12, 32'h0);
      tests++; if (load_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b required 0", load_valid); end
      tests++; if (load_data !== 32'h0) begin fails++; $display("FAIL idle_data: got %h required 0", load_data); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL idle_mem_load: got %b required 0", mem_load); end
   endtask

   task automatic test_load_store();
      drive(1'b1, 1'b1, 8'h04, 32'd3);
      exp_q.push_back({8'h04, 32'd3});
      tests++; if (load_data !== 32'd9) begin fails++; $display("FAIL ls_old_data: got %h required 9", load_data); end
      tests++; if (mem_load !== 1'b1) begin fails++; $display("FAIL ls_mem_load: got %b required 1", mem_load); end
`ifdef STORE_BUFFER_FWD_EN
      drive(1'b1, 1'b0, 8'h04, 32'h0);
      tests++; if (load_data !== 32'd3) begin fails++; $display("FAIL ls_new_data: got %h required 3", load_data); end
      tests++; if (mem_load !== 1'b0) begin fails++; $display("FAIL ls_new_mem_load: got %b required 0", mem_load); end
      drive(1'b0, 1'b0, 8'h00, 32'h0);
`else
      drive(1'b1, 1'b0, 8'h04, 32'h0);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL ls_hit_stall: got %b required 1", stall); end
      drive(1'b1, 1'b0, 8'h04, 32'h0);
      tests++; if (load_data !== 32'd3) begin fails++; $display("FAIL ls_new_data: got %h required 3", load_data); end
`endif
      drive(1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic test_reset_flush();
      drive(1'b1, 1'b1, 8'h40, 32'd1);
      drive(1'b1, 1'b1, 8'h41, 32'd2);
      drive(1'b1, 1'b1, 8'h42, 32'd3);
      @(negedge clock);
      reset = 1'b1;
      load = 1'b0;
      store = 1'b1;
      address = 8'h43;
      store_data = 32'd4;
      #1;
      @(negedge clock);
      reset = 1'b0;
      store = 1'b0;
      #1;
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b required 0", stall); end
      tests++; if (mem_store !== 1'b0) begin fails++; $display("FAIL flush_mem_store: got %b required 0", mem_store); end
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 8'h00, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (mem[8'h40 + i] !== 32'h0) begin
            fails++;
            $display("FAIL flush_mem%0d: got %h required 0", i, mem[8'h40 + i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[4] = 32'd9;
      mem[12] = 32'hAB;
      mem[8'h10] = 32'h77;
      test_reset();
      test_drain();
      test_full();
      test_forward();
      test_miss();
      test_load_store();
      test_reset_flush();
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_left: got %0d pending required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
